// File: rtl/alu_if.sv
// alu_if: bus to the combinational ALU; operands and op code out, result and status back
// Ports: a, b (WIDTH) operands; op (2) op code; result (WIDTH) ALU result; status ALU zero-on-subtract flag
// Modports: master drives a/b/op (sequencer side), slave drives result/status (ALU side)
interface alu_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic [WIDTH-1:0] result;
  logic             status;
  modport master (output a, b, op, input result, status);
  modport slave  (input a, b, op, output result, status);
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: collects A, B and op code from shared switches, runs one ALU cycle, holds the result for display
// Ports: clk; rst_n async active-low reset; data_in_i operand or op code in [1:0]; enter_i async confirm button;
//   clear_i sync soft clear; alu master side of the ALU bus; disp_value_o/disp_zero_o display value and zero flag;
//   stage_o entry prompt (0 GET_A, 1 GET_B, 2 GET_OP, 3 EXEC, 4 SHOW); done_o one-cycle result pulse;
//   op_count_o completed operations
// Build option: ALU_SEQ_CHAIN_EN makes an enter in SHOW reuse the result as operand A and skip GET_A
module alu_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             enter_i,
  input  logic             clear_i,
  alu_if.master            alu,
  output logic [WIDTH-1:0] disp_value_o,
  output logic             disp_zero_o,
  output logic [2:0]       stage_o,
  output logic             done_o,
  output logic [CNT_W-1:0] op_count_o
);
  typedef enum logic [2:0] {GET_A = 3'd0, GET_B = 3'd1, GET_OP = 3'd2, EXEC = 3'd3, SHOW = 3'd4} state_t;
  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic             prev_q;
  logic             enter_edge;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]       op_q, op_d;
  logic             zero_q, zero_d, done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // sync and edge flops reset high so a button held through reset release is not seen as a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], enter_i};
      prev_q <= sync_q[1];
    end
  end
  assign enter_edge = sync_q[1] & ~prev_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    if (clear_i) begin
      state_d = GET_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      res_d   = '0;
      zero_d  = 1'b0;
    end else begin
      case (state_q)
        GET_A:  if (enter_edge) begin a_d = data_in_i; state_d = GET_B; end
        GET_B:  if (enter_edge) begin b_d = data_in_i; state_d = GET_OP; end
        GET_OP: if (enter_edge) begin op_d = data_in_i[1:0]; state_d = EXEC; end
        EXEC: begin
          res_d   = alu.result;
          zero_d  = alu.status;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = SHOW;
        end
        SHOW: if (enter_edge) begin
`ifdef ALU_SEQ_CHAIN_EN
          a_d     = res_q;
          state_d = GET_B;
`else
          state_d = GET_A;
`endif
        end
        default: state_d = GET_A;
      endcase
    end
  end
  assign alu.a        = a_q;
  assign alu.b        = b_q;
  assign alu.op       = op_q;
  assign disp_value_o = (state_q == EXEC || state_q == SHOW) ? res_q : data_in_i;
  assign disp_zero_o  = zero_q;
  assign stage_o      = state_q;
  assign done_o       = done_q;
  assign op_count_o   = cnt_q;
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator for the team's combinational ALU (a, b, op_code in; result, status out).
- Collects operand A, operand B and a 2-bit op code one at a time from a shared WIDTH-bit data input, each entry confirmed by an `enter` pulse.
- Drives the ALU inputs, samples result and status after one execute cycle, and holds them for the seven-segment display path.
- Exposes the current entry stage so the display can show a prompt.

Parameters:
- WIDTH, 4, operand/result width in bits; must be >= 2 (op code is taken from the low 2 bits of data_in).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  operand value, or op code in bits [1:0]; switch-driven and may change at any time.
- enter  input  1  confirm button, asynchronous level; a rising edge advances the sequence.
- clear  input  1  synchronous soft clear, active high.
- alu_result  input  WIDTH  result returned by the ALU.
- alu_status  input  1  ALU zero-on-subtract flag.
- alu_a  output  WIDTH  operand A to the ALU.
- alu_b  output  WIDTH  operand B to the ALU.
- alu_op  output  2  op code to the ALU: 00 add, 01 sub, 10 and, 11 xor.
- disp_value  output  WIDTH  value for the display.
- disp_zero  output  1  latched alu_status.
- stage  output  3  0 GET_A, 1 GET_B, 2 GET_OP, 3 EXEC, 4 SHOW.
- done  output  1  one-cycle pulse when a result is latched.
- op_count  output  CNT_W  number of completed operations.

Behaviour:
- Reset (rst_n low, async):
  - State GET_A; alu_a, alu_b, alu_op, latched result, disp_zero, done and op_count all 0.
  - Both synchronizer flops and the edge-detect flop for `enter` reset to 1, so an `enter` held high through reset release generates no edge.
- `enter` path: 2-flop synchronizer, then rising-edge detect. enter_edge is a single-cycle pulse 2 clocks after `enter` rises. Further edges need `enter` to return low first.
- FSM transitions (all captures use data_in sampled on the clock edge where enter_edge=1):
  - GET_A: enter_edge -> alu_a <= data_in; go to GET_B.
  - GET_B: enter_edge -> alu_b <= data_in; go to GET_OP.
  - GET_OP: enter_edge -> alu_op <= data_in[1:0]; go to EXEC.
  - EXEC: exactly 1 cycle; enter_edge ignored. On the exiting edge: latch result <= alu_result, disp_zero <= alu_status, done <= 1, op_count <= op_count+1 (wraps 2^CNT_W-1 -> 0). Go to SHOW.
  - SHOW: done returns to 0 after 1 cycle. Outputs held. enter_edge -> go to GET_A (see Optional Feature); alu_a, alu_b and alu_op hold their old values until overwritten.
- alu_a, alu_b and alu_op only change at capture edges. They are stable for the whole EXEC cycle, one cycle after the GET_OP capture.
- disp_value: live data_in in GET_A/GET_B/GET_OP; latched result in EXEC and SHOW. disp_zero is only updated in EXEC.
- clear:
  - Has priority over enter_edge in every state.
  - Next state GET_A; zeroes alu_a, alu_b, alu_op, latched result, disp_zero and done.
  - op_count is preserved.
- No arithmetic is done in this block. Result width and wrap behaviour are the ALU's (mod 2^WIDTH).
- Async reset mid-sequence aborts immediately with no partial capture retained.

Optional Feature:
- Macro: ALU_SEQ_CHAIN_EN.
- Defined: in SHOW, enter_edge loads alu_a <= latched result and goes to GET_B, skipping GET_A (accumulator chaining). data_in is ignored on that edge.
- Not defined: enter_edge in SHOW goes to GET_A, as above.

Test Plan:
- Reset; enter edges with data_in 3, 5, 00 -> alu_a=3, alu_b=5, alu_op=00; next cycle stage=3, then stage=4, disp_value=8, disp_zero=0, done high 1 cycle, op_count=1.
- Sequence 7, 7, 01 -> disp_value=0, disp_zero=1. Then 12, 6, 00 -> disp_value=2 (wrap). Then 2, 5, 01 -> disp_value=13, disp_zero=0.
- Hold enter=1 across rst_n release, keep it high 10 cycles -> stage stays 0, alu_a=0. Drop then raise enter with data_in=9 -> alu_a=9 captured exactly 2 cycles after the rise.
- In GET_OP, pulse clear in the same cycle as enter_edge -> stage=0, alu_a=alu_b=alu_op=0, op_count unchanged. Assert rst_n low in EXEC -> all outputs 0 immediately, no done pulse.
- Drive 255 operations with CNT_W=8, then one more -> op_count goes 255 -> 0.
- With ALU_SEQ_CHAIN_EN: 3, 5, add -> SHOW 8; enter with data_in=1 -> alu_a=8, stage=1; then 4, sub -> disp_value=4. Without the macro the same enter -> stage=0.
